reset_sequencer: RTL and testbench

//  Generates the sequenced active-low reset (oNRst) and clock-enable tick that feed the clock

---
 rtl/clkrst_pkg.sv | 15 +
 rtl/reset_sequencer_if.sv | 28 ++
 rtl/bit_synchronizer.sv | 36 +++
 rtl/reset_sequencer.sv | 129 ++++++++++++
 tb/tb_reset_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clkrst_pkg.sv
// Shared types and constants for the reset sequencer.
package clkrst_pkg;

    // Sequencing states; the encoding is visible on oState.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } rstseq_state_t;

    // Cycles spent in DRAIN before returning to WAIT_LOCK.
    localparam int DrainCycles = 2;

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its consumer.
// The sequencer is the slave; the consumer drives lock/soft-reset requests.
interface reset_sequencer_if;
    logic       iLocked;
    logic       iSoftRst;
    logic       oNRst;
    logic       oClkEn;
    logic       oReady;
    logic [1:0] oState;

    modport master (
        output iLocked,
        output iSoftRst,
        input  oNRst,
        input  oClkEn,
        input  oReady,
        input  oState
    );

    modport slave (
        input  iLocked,
        input  iSoftRst,
        output oNRst,
        output oClkEn,
        output oReady,
        output oState
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by iRst.
module bit_synchronizer #(
    parameter int Stages = 2
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iD,
    output logic oQ
);

    logic [Stages-1:0] sync_q;
    logic [Stages-1:0] sync_d;

    // Each stage takes the previous stage's value; stage 0 takes the raw input.
    generate
        for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = iD;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    // Shift chain; asynchronously cleared so lock is never seen during reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign oQ = sync_q[Stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a synchronized clock-lock flag, holds the
// downstream active-low reset for a fixed count, then releases it and
// generates a divided clock-enable tick. Lock loss or a soft-reset request
// while running drains back into reset for a fixed number of cycles.
module reset_sequencer
    import clkrst_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int HoldCycles = 16,
    parameter int ClkDiv     = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    reset_sequencer_if.slave    seq_if
);

    localparam int CntW = $clog2(HoldCycles + 1);
    localparam int DivW = $clog2(ClkDiv + 1);

    localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(DrainCycles - 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(ClkDiv - 1);

    rstseq_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            nrst_q, nrst_d;
    logic            clken_q, clken_d;
    logic            ready_q, ready_d;
    logic            lock_s;

    bit_synchronizer #(
        .Stages (SyncStages)
    ) u_lock_sync (
        .iClk (iClk),
        .iRst (iRst),
        .iD   (seq_if.iLocked),
        .oQ   (lock_s)
    );

    // Next-state and next-output decode; outputs are computed for the
    // destination state so they change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        nrst_d  = 1'b0;
        clken_d = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (seq_if.iSoftRst) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = '0;
                    nrst_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RUN: begin
                if (!lock_s || seq_if.iSoftRst) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    div_d   = '0;
                end else begin
                    nrst_d  = 1'b1;
                    ready_d = 1'b1;
                    if (div_q == DivLast) begin
                        div_d   = '0;
                        clken_d = 1'b1;
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DrainLast) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                div_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; iRst forces everything idle at once.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            div_q   <= '0;
            nrst_q  <= 1'b0;
            clken_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            nrst_q  <= nrst_d;
            clken_q <= clken_d;
            ready_q <= ready_d;
        end
    end

    assign seq_if.oNRst  = nrst_q;
    assign seq_if.oClkEn = clken_q;
    assign seq_if.oReady = ready_q;
    assign seq_if.oState = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: two instances (default parameters and
// SyncStages=3/HoldCycles=1/ClkDiv=1) driven with the same inputs, checked
// every cycle against an edge-timestamp reference model plus directed checks.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic lock_in;
    logic soft_in;

    always #5 clk = ~clk;

    reset_sequencer_if bus_a ();
    reset_sequencer_if bus_b ();

    assign bus_a.iLocked  = lock_in;
    assign bus_a.iSoftRst = soft_in;
    assign bus_b.iLocked  = lock_in;
    assign bus_b.iSoftRst = soft_in;

    reset_sequencer dut_a (
        .iClk   (clk),
        .iRst   (rst),
        .seq_if (bus_a)
    );

    reset_sequencer #(
        .SyncStages (3),
        .HoldCycles (1),
        .ClkDiv     (1)
    ) dut_b (
        .iClk   (clk),
        .iRst   (rst),
        .seq_if (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, the phase and the edge at which the
    // phase (or the hold restart) began; timing derived from edge differences.
    int         cfg_s  [2] = '{2, 3};
    int         cfg_hc [2] = '{16, 1};
    int         cfg_cd [2] = '{4, 1};
    int         m_state[2];
    int         m_t0   [2];
    logic [7:0] m_hist [2];
    int         edge_n;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0;
            m_t0[d]    = 0;
            m_hist[d]  = '0;
        end
        edge_n = 0;
    endtask

    task automatic model_step(input int d, input logic lk_in, input logic sr);
        logic lk;
        lk        = m_hist[d][cfg_s[d]-1];
        m_hist[d] = {m_hist[d][6:0], lk_in};
        case (m_state[d])
            0: if (lk) begin m_state[d] = 1; m_t0[d] = edge_n; end
            1: begin
                if (!lk) m_state[d] = 0;
                else if (sr) m_t0[d] = edge_n;
                else if (edge_n - m_t0[d] == cfg_hc[d]) begin
                    m_state[d] = 2;
                    m_t0[d]    = edge_n;
                end
            end
            2: if (!lk || sr) begin m_state[d] = 3; m_t0[d] = edge_n; end
            default: if (edge_n - m_t0[d] == 2) m_state[d] = 0;
        endcase
    endtask

    // Returns {state[1:0], ready, clken, nrst}.
    function automatic logic [4:0] model_out(input int d);
        logic run;
        logic ce;
        run = (m_state[d] == 2);
        ce  = run && (edge_n > m_t0[d]) && (((edge_n - m_t0[d]) % cfg_cd[d]) == 0);
        return {m_state[d][1:0], run, ce, run};
    endfunction

    task automatic check_all(input string tag);
        logic [4:0] ea;
        logic [4:0] eb;
        ea = model_out(0);
        eb = model_out(1);
        check($sformatf("%s e%0d a_state", tag, edge_n), bus_a.oState, ea[4:3]);
        check($sformatf("%s e%0d a_ready", tag, edge_n), {1'b0, bus_a.oReady}, {1'b0, ea[2]});
        check($sformatf("%s e%0d a_clken", tag, edge_n), {1'b0, bus_a.oClkEn}, {1'b0, ea[1]});
        check($sformatf("%s e%0d a_nrst", tag, edge_n), {1'b0, bus_a.oNRst}, {1'b0, ea[0]});
        check($sformatf("%s e%0d b_state", tag, edge_n), bus_b.oState, eb[4:3]);
        check($sformatf("%s e%0d b_ready", tag, edge_n), {1'b0, bus_b.oReady}, {1'b0, eb[2]});
        check($sformatf("%s e%0d b_clken", tag, edge_n), {1'b0, bus_b.oClkEn}, {1'b0, eb[1]});
        check($sformatf("%s e%0d b_nrst", tag, edge_n), {1'b0, bus_b.oNRst}, {1'b0, eb[0]});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            edge_n++;
            for (int d = 0; d < 2; d++) model_step(d, lock_in, soft_in);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst     = 1'b0;
        lock_in = 1'b0;
        soft_in = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all("reset");
        repeat (3) tick("reset");

        // Lock steady high: release at edge 19, ticks at 23, 27.
        lock_in = 1'b1;
        rst     = 1'b0;
        repeat (18) tick("t1");
        check("t1 nrst_e18", {1'b0, bus_a.oNRst}, 2'd0);
        tick("t1");
        check("t1 nrst_e19", {1'b0, bus_a.oNRst}, 2'd1);
        check("t1 ready_e19", {1'b0, bus_a.oReady}, 2'd1);
        check("t1 state_e19", bus_a.oState, 2'd2);
        repeat (3) tick("t1");
        check("t1 clken_e22", {1'b0, bus_a.oClkEn}, 2'd0);
        tick("t1");
        check("t1 clken_e23", {1'b0, bus_a.oClkEn}, 2'd1);
        tick("t1");
        check("t1 clken_e24", {1'b0, bus_a.oClkEn}, 2'd0);
        repeat (3) tick("t1");
        check("t1 clken_e27", {1'b0, bus_a.oClkEn}, 2'd1);

        // Lock loss in RUN: DRAIN at edge 30 for two cycles, then re-hold.
        lock_in = 1'b0;
        repeat (2) tick("t4");
        check("t4 state_e29", bus_a.oState, 2'd2);
        tick("t4");
        check("t4 state_e30", bus_a.oState, 2'd3);
        check("t4 nrst_e30", {1'b0, bus_a.oNRst}, 2'd0);
        check("t4 clken_e30", {1'b0, bus_a.oClkEn}, 2'd0);
        tick("t4");
        check("t4 state_e31", bus_a.oState, 2'd3);
        tick("t4");
        check("t4 state_e32", bus_a.oState, 2'd0);
        lock_in = 1'b1;
        repeat (18) tick("t4");
        check("t4 nrst_e50", {1'b0, bus_a.oNRst}, 2'd0);
        tick("t4");
        check("t4 nrst_e51", {1'b0, bus_a.oNRst}, 2'd1);
        repeat (2) tick("t4");

        // Asynchronous reset between edges while running.
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("t5");
        check("t5 async_nrst", {1'b0, bus_a.oNRst}, 2'd0);
        check("t5 async_state", bus_a.oState, 2'd0);
        repeat (2) tick("t5");

        // Lock absent for 49 edges, raised before edge 50: release at edge 68.
        lock_in = 1'b0;
        rst     = 1'b0;
        repeat (49) tick("t2");
        check("t2 state_e49", bus_a.oState, 2'd0);
        lock_in = 1'b1;
        repeat (18) tick("t2");
        check("t2 nrst_e67", {1'b0, bus_a.oNRst}, 2'd0);
        tick("t2");
        check("t2 nrst_e68", {1'b0, bus_a.oNRst}, 2'd1);

        // Soft reset while hold counter reads 10: release moves to edge 30.
        rst = 1'b1;
        repeat (2) tick("t3");
        rst = 1'b0;
        repeat (13) tick("t3");
        soft_in = 1'b1;
        tick("t3");
        soft_in = 1'b0;
        repeat (15) tick("t3");
        check("t3 nrst_e29", {1'b0, bus_a.oNRst}, 2'd0);
        tick("t3");
        check("t3 nrst_e30", {1'b0, bus_a.oNRst}, 2'd1);

        // Fast instance: release at edge 5, continuous ticks, combined drain cause.
        rst = 1'b1;
        repeat (2) tick("t6");
        rst = 1'b0;
        repeat (4) tick("t6");
        check("t6 b_nrst_e4", {1'b0, bus_b.oNRst}, 2'd0);
        tick("t6");
        check("t6 b_nrst_e5", {1'b0, bus_b.oNRst}, 2'd1);
        tick("t6");
        check("t6 b_clken_e6", {1'b0, bus_b.oClkEn}, 2'd1);
        tick("t6");
        check("t6 b_clken_e7", {1'b0, bus_b.oClkEn}, 2'd1);
        lock_in = 1'b0;
        repeat (3) tick("t6");
        soft_in = 1'b1;
        tick("t6");
        soft_in = 1'b0;
        check("t6 b_state_e11", bus_b.oState, 2'd3);
        tick("t6");
        check("t6 b_state_e12", bus_b.oState, 2'd3);
        tick("t6");
        check("t6 b_state_e13", bus_b.oState, 2'd0);
        tick("t6");
        check("t6 b_state_e14", bus_b.oState, 2'd0);

        // Randomized lock/soft-reset traffic with occasional async resets.
        lock_in = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) lock_in = ~lock_in;
            soft_in = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                check_all("rand_rst");
                tick("rand_rst");
                rst = 1'b0;
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
